// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - NOP_INSTR        : encoding presented to decode when no instruction is valid
//   - DEFAULT_RESET_PC : default PC after reset
//   - fetch_state_t    : outstanding-request FSM states
//   - fifo_entry_t     : instruction buffer entry {pc, ir}
//   - align_word()     : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // S_IDLE: nothing outstanding
    // S_WAIT: one request outstanding, its data will be kept
    // S_DROP: one request outstanding, its data belongs to a squashed path
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fifo_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_fifo
// Synchronous first-word-fall-through buffer of fetched {pc, ir} pairs.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_flush          : discard all entries (taken redirect)
//   i_push, i_push_data : write one entry
//   i_pop            : consume the head entry
//   o_head           : current head entry (valid when !o_empty)
//   o_count, o_empty : occupancy
// Push and pop in the same cycle on a full buffer are legal; the caller
// never pushes into a full buffer without popping and never pops when empty.
// -----------------------------------------------------------------------------
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fifo_entry_t   i_push_data,
    input  logic          i_pop,
    output fifo_entry_t   o_head,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is read combinationally so decode sees the oldest entry the cycle
    // after it was written; the buffer is tiny, so this maps to LUT storage.
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, buffers returned words with their PCs and hands them to
// decode. Taken branches/jumps from execute redirect the PC and squash
// everything in flight.
// Ports:
//   i_clk, i_rst_n                      : clock, synchronous active-low reset
//   o_imem_req_valid, i_imem_req_ready  : request handshake
//   o_imem_addr                         : word-aligned fetch address
//   i_imem_rsp_valid, i_imem_rsp_data   : in-order read response
//   i_redirect, i_redirect_pc           : redirect from execute
//   o_id_valid, i_id_ready              : decode handshake
//   o_id_ir, o_id_pc                    : instruction and its PC (NOP/0 when idle)
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_ir,
    output logic [31:0] o_id_pc
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_pc;

    logic [CW-1:0] w_count;
    logic          w_fifo_empty;
    fifo_entry_t   w_head;
    fifo_entry_t   w_push_entry;

    logic          w_id_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_outstanding;
    logic          w_credit_ok;

    assign w_outstanding = (r_state != S_IDLE);

    // A redirect squashes the buffer this cycle, so nothing may be handed off.
    assign w_id_valid = i_rst_n && !i_redirect && !w_fifo_empty;
    assign w_pop      = w_id_valid && i_id_ready;

    // Credit check: count + outstanding - pop < depth, rearranged as
    // count + outstanding < depth + pop so nothing can underflow.
    assign w_credit_ok = (CW1'(w_count) + CW1'(w_outstanding))
                       < (CW1'(FIFO_DEPTH) + CW1'(w_pop));

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_req_valid  = 1'b0;
        w_accept     = 1'b0;

        // A new request may go out when the slot is free or being freed by
        // the response arriving this cycle.
        w_req_valid = i_rst_n && !i_redirect
                    && ((r_state == S_IDLE) || i_imem_rsp_valid)
                    && w_credit_ok;
        w_accept    = w_req_valid && i_imem_req_ready;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    w_state_next = i_imem_rsp_valid ? S_IDLE : S_DROP;
                end else if (i_imem_rsp_valid) begin
                    w_push       = 1'b1;
                    w_state_next = w_accept ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                // The stale word is thrown away; a further redirect just
                // keeps waiting for it.
                if (i_imem_rsp_valid) begin
                    w_state_next = w_accept ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_fetch_pc remembers the address of the request in flight so the
    // returned word can be tagged with its own PC.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc       <= align_word(RESET_PC);
            r_fetch_pc <= align_word(RESET_PC);
        end else if (i_redirect) begin
            r_pc <= align_word(i_redirect_pc);
        end else if (w_accept) begin
            r_pc       <= r_pc + 32'd4;
            r_fetch_pc <= r_pc;
        end
    end

    assign w_push_entry = '{pc: r_fetch_pc, ir: i_imem_rsp_data};

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_empty     (w_fifo_empty)
    );

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_addr      = r_pc;
    assign o_id_valid       = w_id_valid;
    assign o_id_ir          = w_id_valid ? w_head.ir : NOP_INSTR;
    assign o_id_pc          = w_id_valid ? w_head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Randomised bench for instr_fetch. A memory model answers requests in order
// after a per-request latency. Expected decode traffic is derived from the
// program-order rule: a returned word is delivered only if no reset or
// redirect happened between its request and its response (tracked with an
// epoch number) and no redirect coincides with the response. Kept words are
// queued; a separate monitor compares every decode-side cycle to the queue.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_pc;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        bit          stale;   // requester forgot it (reset in between)
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];    // {pc, ir} expected at decode, oldest first

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          epoch     = 0;
    logic [31:0] fetch_pc  = RST_PC;
    int          ready_pct = 100;
    int          idr_pct   = 100;
    int          k_min     = 1;
    int          k_max     = 1;
    bit          prev_stall = 0;
    logic [31:0] prev_addr  = '0;

    instr_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_addr      (imem_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_id_valid       (id_valid),
        .i_id_ready       (id_ready),
        .o_id_ir          (id_ir),
        .o_id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then evaluate what
    // the next rising edge will do and update the reference model.
    task automatic cycle(input bit rv, input bit dv, input logic [31:0] dpc);
        bit    rsp_now;
        int    live;
        int    k;
        int    due;
        pend_t e;
        @(negedge clk);
        rst_n          = rv;
        redirect       = dv;
        redirect_pc    = dpc;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        rsp_now        = rv && (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        if (rsp_now) imem_rsp_data = mem_word(pend_q[0].addr);
        else         imem_rsp_data = $urandom();
        #1;
        if (!rv) begin
            check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("rst_id_valid", {31'd0, id_valid}, 32'd0);
            epoch++;
            exp_q.delete();
            fetch_pc = RST_PC;
            // Memory is not reset: a response still owed arrives in the
            // first cycle after reset and must be ignored.
            if (pend_q.size() > 0) begin
                e = pend_q[0];
                e.stale = 1'b1;
                e.due = cyc + 1;
                pend_q.delete();
                pend_q.push_back(e);
            end
            prev_stall = 1'b0;
        end else begin
            live = 0;
            foreach (pend_q[i]) if (!pend_q[i].stale) live++;
            if (rsp_now && !pend_q[0].stale) live--;
            if (live > 0) check("one_outstanding", {31'd0, imem_req_valid}, 32'd0);
            if (dv) begin
                check("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
                check("redir_id_valid", {31'd0, id_valid}, 32'd0);
            end
            if (prev_stall && !dv) begin
                check("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
                check("hold_addr", imem_addr, prev_addr);
            end
            if (imem_req_valid) check("fetch_addr", imem_addr, fetch_pc);
            if (rsp_now) begin
                e = pend_q.pop_front();
                if (!e.stale && e.epoch == epoch && !dv)
                    exp_q.push_back({e.addr, mem_word(e.addr)});
            end
            if (imem_req_valid && imem_req_ready) begin
                k   = $urandom_range(k_max, k_min);
                due = cyc + k;
                if (pend_q.size() > 0 && pend_q[$].due >= due) due = pend_q[$].due + 1;
                pend_q.push_back('{addr: imem_addr, epoch: epoch, due: due, stale: 1'b0});
                fetch_pc = fetch_pc + 32'd4;
            end
            if (dv) begin
                epoch++;
                exp_q.delete();
                fetch_pc = {dpc[31:2], 2'b00};
            end
            prev_stall = imem_req_valid && !imem_req_ready;
            prev_addr  = imem_addr;
        end
        cyc++;
    endtask

    // Monitor: every cycle, compare the decode-side outputs to the queue.
    always @(negedge clk) begin
        #2;
        if (id_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("id_unexpected_valid", {31'd0, id_valid}, 32'd0);
            end else begin
                check("id_pc", id_pc, exp_q[0][63:32]);
                check("id_ir", id_ir, exp_q[0][31:0]);
                if (id_ready) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_id_ir", id_ir, NOP);
            check("idle_id_pc", id_pc, 32'd0);
        end
    end

    task automatic wait_accept(input string name, input logic [31:0] addr, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                check(name, imem_addr, addr);
            end
        end
        check({name, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_accept_of(input logic [31:0] addr, input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (imem_req_valid && imem_req_ready && imem_addr == addr) found = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;

        // Reset, then streaming with single-cycle memory.
        repeat (3) cycle(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (i == 0) check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
            if (i < 2) check("latency_no_valid", {31'd0, id_valid}, 32'd0);
            else       check("throughput_valid", {31'd0, id_valid}, 32'd1);
        end

        // Decode backpressure: buffer fills, requests stop, then drain.
        idr_pct = 0;
        repeat (5) cycle(1'b1, 1'b0, 32'd0);
        check("full_req_stopped", {31'd0, imem_req_valid}, 32'd0);
        check("full_id_valid", {31'd0, id_valid}, 32'd1);
        idr_pct = 100;
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Slow memory, redirect one cycle after the request for 8 is accepted.
        cycle(1'b0, 1'b0, 32'd0);
        k_min = 3; k_max = 3;
        wait_accept_of(32'h8, 30, ok);
        check("accept_8_seen", {31'd0, ok}, 32'd1);
        cycle(1'b1, 1'b1, 32'h100);
        wait_accept("drop_next_addr", 32'h100, 10);
        repeat (10) cycle(1'b1, 1'b0, 32'd0);

        // Redirect coinciding with the response for address 4.
        cycle(1'b0, 1'b0, 32'd0);
        k_min = 1; k_max = 1;
        wait_accept_of(32'h4, 10, ok);
        check("accept_4_seen", {31'd0, ok}, 32'd1);
        cycle(1'b1, 1'b1, 32'h203);
        wait_accept("rsp_redir_next_addr", 32'h200, 5);
        repeat (8) cycle(1'b1, 1'b0, 32'd0);

        // Memory not ready: request held, then withdrawn by a redirect.
        ready_pct = 0;
        repeat (6) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 32'h340);
        ready_pct = 100;
        cycle(1'b1, 1'b0, 32'd0);
        check("post_stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_stall_addr", imem_addr, 32'h340);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Reset with words buffered and a request in flight.
        k_min = 2; k_max = 2; idr_pct = 0;
        repeat (4) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("post_reset_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_reset_addr", imem_addr, RST_PC);
        check("post_reset_id_valid", {31'd0, id_valid}, 32'd0);
        idr_pct = 100;
        repeat (8) cycle(1'b1, 1'b0, 32'd0);

        // Random traffic with redirects and occasional resets.
        k_min = 1; k_max = 3; ready_pct = 70; idr_pct = 70;
        for (int i = 0; i < 600; i++) begin
            bit dv = ($urandom_range(99) < 4);
            bit rv = ($urandom_range(199) != 0);
            cycle(rv, dv && rv, $urandom() & 32'h0000_FFFF);
        end

        ready_pct = 100; idr_pct = 100; k_min = 1; k_max = 1;
        repeat (20) cycle(1'b1, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
